// File: rtl/inc_param.sv
// inc_param: loadable up/down counter over 0..MAXVAL with wrap or saturate at the range ends.
module inc_param #(
    parameter int              WIDTH  = 8,
    parameter logic [WIDTH-1:0] MAXVAL = {WIDTH{1'b1}},
    parameter bit              SAT    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf
);
    logic             at_top, at_bot, bnd;
    logic [WIDTH-1:0] inc, dec, nxt;
    always_comb begin
        at_top = cnt == MAXVAL;
        at_bot = cnt == '0;
        tc     = up ? at_top : at_bot;
        bnd    = en && tc;
        inc    = at_top ? (SAT ? MAXVAL : '0) : cnt + WIDTH'(1);
        dec    = at_bot ? (SAT ? '0 : MAXVAL) : cnt - WIDTH'(1);
        nxt    = ld ? (data > MAXVAL ? MAXVAL : data) : !en ? cnt : up ? inc : dec;
    end
    // a load edge never reports a boundary step, even if en would have hit one
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            cnt <= nxt;
            ovf <= !ld && bnd;
        end
endmodule

// File: tb/tb_inc_param.sv
// tb_inc_param: directed checks of three inc_param configurations against hand-computed values.
module tb_inc_param;
    logic       clk = 1'b0, rst = 1'b1;
    logic       a_ld = 0, a_en = 0, a_up = 0, a_tc, a_ovf;
    logic [7:0] a_data = 0, a_cnt;
    logic       b_ld = 0, b_en = 0, b_up = 0, b_tc, b_ovf;
    logic [3:0] b_data = 0, b_cnt;
    logic       c_ld = 0, c_en = 0, c_up = 0, c_tc, c_ovf;
    logic [3:0] c_data = 0, c_cnt;
    int         n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    inc_param #(.WIDTH(8)) u_a (
        .clk(clk), .rst(rst), .ld(a_ld), .en(a_en), .up(a_up), .data(a_data),
        .cnt(a_cnt), .tc(a_tc), .ovf(a_ovf));
    inc_param #(.WIDTH(4), .MAXVAL(4'd9), .SAT(1'b1)) u_b (
        .clk(clk), .rst(rst), .ld(b_ld), .en(b_en), .up(b_up), .data(b_data),
        .cnt(b_cnt), .tc(b_tc), .ovf(b_ovf));
    inc_param #(.WIDTH(4), .MAXVAL(4'd9), .SAT(1'b0)) u_c (
        .clk(clk), .rst(rst), .ld(c_ld), .en(c_en), .up(c_up), .data(c_data),
        .cnt(c_cnt), .tc(c_tc), .ovf(c_ovf));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_a_cnt", a_cnt, 0);
        chk("rst_a_ovf", a_ovf, 0);
        chk("rst_b_cnt", b_cnt, 0);
        chk("rst_c_ovf", c_ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        // full 8-bit wrap run
        a_en = 1; a_up = 1;
        for (int i = 1; i <= 256; i++) begin
            step();
            chk("run_cnt", a_cnt, i % 256);
            chk("run_ovf", a_ovf, i == 256);
            if (i == 255) chk("run_tc255", a_tc, 1);
        end
        a_en = 0;
        step();
        chk("run_hold_cnt", a_cnt, 0);
        chk("run_ovf_drop", a_ovf, 0);
        // load beats enable, including at a boundary
        a_ld = 1; a_data = 255;
        step();
        chk("ld255_cnt", a_cnt, 255);
        a_data = 3; a_en = 1; a_up = 1;
        step();
        chk("ld_en_cnt", a_cnt, 3);
        chk("ld_en_ovf", a_ovf, 0);
        a_data = 10; a_en = 0;
        step();
        a_ld = 0; a_en = 1; a_up = 0;
        step();
        chk("down_cnt", a_cnt, 9);
        chk("down_ovf", a_ovf, 0);
        a_up = 1;
        step();
        chk("dir_flip_cnt", a_cnt, 10);
        // saturating instance
        b_ld = 1; b_data = 7;
        step();
        chk("sat_ld7", b_cnt, 7);
        b_ld = 0; b_en = 1; b_up = 1;
        step();
        chk("sat_c8", b_cnt, 8);
        chk("sat_o8", b_ovf, 0);
        chk("sat_t8", b_tc, 0);
        step();
        chk("sat_c9a", b_cnt, 9);
        chk("sat_o9a", b_ovf, 0);
        chk("sat_t9a", b_tc, 1);
        step();
        chk("sat_c9b", b_cnt, 9);
        chk("sat_o9b", b_ovf, 1);
        step();
        chk("sat_c9c", b_cnt, 9);
        chk("sat_o9c", b_ovf, 1);
        chk("sat_t9c", b_tc, 1);
        b_en = 0;
        step();
        chk("sat_o_drop", b_ovf, 0);
        b_ld = 1; b_data = 15;
        step();
        chk("sat_ld15", b_cnt, 9);
        b_data = 0;
        step();
        b_ld = 0; b_en = 1; b_up = 0;
        step();
        chk("sat_dn_c", b_cnt, 0);
        chk("sat_dn_o", b_ovf, 1);
        b_en = 0;
        // wrapping instance with MAXVAL=9
        c_ld = 1; c_data = 14;
        step();
        chk("wrap_ld14", c_cnt, 9);
        chk("wrap_ld_ovf", c_ovf, 0);
        c_data = 0;
        step();
        chk("wrap_ld0", c_cnt, 0);
        c_ld = 0; c_en = 1; c_up = 0;
        step();
        chk("wrap_dn_c", c_cnt, 9);
        chk("wrap_dn_o", c_ovf, 1);
        c_up = 1;
        step();
        chk("wrap_up_c", c_cnt, 0);
        chk("wrap_up_o", c_ovf, 1);
        c_en = 0;
        step();
        chk("wrap_o_drop", c_ovf, 0);
        // asynchronous reset mid-cycle
        a_ld = 1; a_en = 0; a_data = 5;
        step();
        chk("pre_rst_cnt", a_cnt, 5);
        a_ld = 0;
        #2 rst = 1;
        #1;
        chk("async_rst_cnt", a_cnt, 0);
        chk("async_rst_ovf", a_ovf, 0);
        a_en = 1; a_up = 1; a_ld = 1; a_data = 7;
        step();
        chk("rst_hold_cnt", a_cnt, 0);
        a_ld = 0;
        #2 rst = 0;
        step();
        chk("post_rst_cnt", a_cnt, 1);
        // tc follows up with no clock
        a_en = 0; a_ld = 1; a_data = 0;
        step();
        a_ld = 0; a_up = 1;
        #1;
        chk("tc_up", a_tc, 0);
        a_up = 0;
        #1;
        chk("tc_dn", a_tc, 1);
        chk("tc_cnt", a_cnt, 0);
        step();
        chk("tc_hold_cnt", a_cnt, 0);
        chk("tc_hold_tc", a_tc, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
